// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, buffer occupancy states and the result entry type.
// Used by alu_core, alu_exec_stage and the single-cycle datapath.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NOP  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_BGTZ = 4'b1010;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_REG_W  = 5;

   // Default-width entry; the exec stage declares the same layout at its own parameter widths.
   typedef struct packed {
      logic [ALU_DATA_W-1:0] result;
      logic                  zero;
      logic                  cond;
      logic [ALU_REG_W-1:0]  rd;
      logic                  ovf;
   } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result, branch condition and signed overflow for one op.
// Overflow detection is built only when ALU_OVF_EN is defined; otherwise ovf is tied low.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        sel_op,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic              cond,
   output logic              ovf
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin
      result = '0;
      cond   = 1'b0;
      case (sel_op)
         OP_ADD:  result = sum;
         OP_SUB:  begin
            result = diff;
            cond   = (op_a == op_b);
         end
         OP_AND:  result = op_a & op_b;
         OP_OR:   result = op_a | op_b;
         OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_BNE:  begin
            result = diff;
            cond   = (op_a != op_b);
         end
         OP_BGTZ: begin
            result = op_a;
            cond   = !op_a[DATA_W-1] && (op_a != '0);
         end
         default: ;
      endcase
   end

`ifdef ALU_OVF_EN
   always_comb begin
      ovf = 1'b0;
      case (sel_op)
         OP_ADD:         ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
         OP_SUB, OP_BNE: ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
         default:        ovf = 1'b0;
      endcase
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: alu_core followed by a 2-entry (main + skid) output buffer with valid/ready on both sides.
// ALU_OVF_EN selects whether ovf carries real signed-overflow information.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main entry valid, skid empty
// ST_FULL  | main and skid valid, input stalled
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        sel_op,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [REG_W-1:0]  rd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              branch_cond,
   output logic [REG_W-1:0]  rd_out,
   output logic              ovf
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              cond;
      logic [REG_W-1:0]  rd;
      logic              ovf;
   } entry_t;

   logic [1:0]        state_q, state_d;
   entry_t            main_q, main_d;
   entry_t            skid_q, skid_d;
   logic              in_ready_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_cond;
   logic              alu_ovf;
   entry_t            new_entry;
   logic              accept;
   logic              drain;

   alu_core #(.DATA_W(DATA_W)) u_alu_core (
      .sel_op (sel_op),
      .op_a   (op_a),
      .op_b   (op_b),
      .result (alu_result),
      .cond   (alu_cond),
      .ovf    (alu_ovf)
   );

   assign new_entry = '{result: alu_result, zero: (alu_result == '0), cond: alu_cond,
                        rd: rd_in, ovf: alu_ovf};

   assign accept = in_valid && in_ready_q;
   assign drain  = (state_q != ST_EMPTY) && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               main_d  = new_entry;
               state_d = ST_ONE;
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_d = new_entry;
               end else if (accept) begin
                  skid_d  = new_entry;
                  state_d = ST_FULL;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: if (drain) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // in_ready comes from next-state so it never depends combinationally on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= '{result: '0, zero: 1'b1, cond: 1'b0, rd: '0, ovf: 1'b0};
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != ST_EMPTY);
   assign result      = main_q.result;
   assign zero        = main_q.zero;
   assign branch_cond = main_q.cond;
   assign rd_out      = main_q.rd;
   assign ovf         = main_q.ovf;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: queue-based reference model checked every cycle, plus directed literal cases.
module tb_alu_exec_stage;

   localparam int DW = 32;
   localparam int RW = 5;
`ifdef ALU_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [3:0]    sel_op = 4'd0;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic [RW-1:0] rd_in = '0;
   logic          in_ready, out_valid, zero, branch_cond, ovf;
   logic [DW-1:0] result;
   logic [RW-1:0] rd_out;

   alu_exec_stage #(.DATA_W(DW), .REG_W(RW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sel_op      (sel_op),
      .op_a        (op_a),
      .op_b        (op_b),
      .rd_in       (rd_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .branch_cond (branch_cond),
      .rd_out      (rd_out),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] result;
      logic          zero;
      logic          cond;
      logic [RW-1:0] rd;
      logic          ovf;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic exp_t ref_op(input logic [3:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [RW-1:0] rd);
      exp_t   e;
      longint sa, sb, r, lim;
      sa = $signed(a);
      sb = $signed(b);
      lim = longint'(1) <<< (DW - 1);
      e.result = '0;
      e.cond = 1'b0;
      e.ovf = 1'b0;
      e.rd = rd;
      r = 0;
      case (op)
         4'd0:  begin e.result = a + b; r = sa + sb; end
         4'd1:  begin e.result = a - b; e.cond = (a == b); r = sa - sb; end
         4'd3:  e.result = (sa < sb) ? 1 : 0;
         4'd4:  e.result = a & b;
         4'd5:  e.result = a | b;
         4'd9:  begin e.result = a - b; e.cond = (a != b); r = sa - sb; end
         4'd10: begin e.result = a; e.cond = (sa > 0); end
         default: ;
      endcase
      if (OVF_ON && (op == 4'd0 || op == 4'd1 || op == 4'd9))
         e.ovf = (r >= lim) || (r < -lim);
      e.zero = (e.result == '0);
      return e;
   endfunction

   // Reference: a FIFO of at most two results in delivery order.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         bit   fo, fi;
         exp_t e;
         fo = (q.size() > 0) && out_ready;
         fi = in_valid && (q.size() < 2);
         e = ref_op(sel_op, op_a, op_b, rd_in);
         if (flush) begin
            q.delete();
         end else begin
            if (fo) void'(q.pop_front());
            if (fi) q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", out_valid, q.size() > 0);
         chk("in_ready", in_ready, q.size() < 2);
         if (q.size() > 0) begin
            chk("result", result, q[0].result);
            chk("zero", zero, q[0].zero);
            chk("branch_cond", branch_cond, q[0].cond);
            chk("rd_out", rd_out, q[0].rd);
            chk("ovf", ovf, q[0].ovf);
         end
      end
   end

   task automatic do_op(input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] rd);
      @(posedge clk); #1;
      in_valid = 1'b1; sel_op = op; op_a = a; op_b = b; rd_in = rd; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return DW'($urandom_range(0, 3));
         4: return 32'hFFFF_FFFF;
         default: return DW'($urandom);
      endcase
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_cond", branch_cond, 0);
      chk("rst_rd", rd_out, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;

      do_op(4'b0000, 7, 5, 5'd3);
      chk("add_result", result, 12);
      chk("add_zero", zero, 0);
      chk("add_cond", branch_cond, 0);
      chk("add_valid", out_valid, 1);
      do_op(4'b0001, 32'h1234, 32'h1234, 5'd4);
      chk("beq_result", result, 0);
      chk("beq_zero", zero, 1);
      chk("beq_cond", branch_cond, 1);
      do_op(4'b1001, 32'h1234, 32'h1234, 5'd4);
      chk("bne_cond", branch_cond, 0);
      do_op(4'b0011, 32'hFFFF_FFFF, 1, 5'd5);
      chk("slt_result", result, 1);
      do_op(4'b1010, 32'h8000_0000, 0, 5'd6);
      chk("bgtz_neg_cond", branch_cond, 0);
      do_op(4'b1010, 1, 0, 5'd6);
      chk("bgtz_pos_cond", branch_cond, 1);
      do_op(4'b0000, 32'h7FFF_FFFF, 1, 5'd7);
      chk("ovf_result", result, 32'h8000_0000);
      chk("ovf_flag", ovf, OVF_ON);
      do_op(4'b1111, 9, 9, 5'd8);
      chk("undef_result", result, 0);

      // Backpressure: two ops fill the buffer, third waits for the first drain.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; sel_op = 4'b0000;
      op_a = 1; op_b = 1; rd_in = 5'd1;
      @(posedge clk); #1; op_a = 2; op_b = 2; rd_in = 5'd2;
      @(negedge clk);
      chk("bp1_result", result, 2);
      chk("bp1_in_ready", in_ready, 1);
      @(posedge clk); #1; op_a = 3; op_b = 3; rd_in = 5'd3;
      @(negedge clk);
      chk("bp2_in_ready", in_ready, 0);
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hold_result", result, 2);
      chk("bp_hold_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_second_result", result, 4);
      chk("bp_second_in_ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      chk("bp_third_result", result, 6);
      chk("bp_third_rd", rd_out, 3);
      @(posedge clk);
      @(negedge clk);
      chk("bp_empty", out_valid, 0);

      // Flush with a full buffer and a valid input in the same cycle.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; sel_op = 4'b0101; op_a = 32'hF0; op_b = 32'h0F;
      repeat (2) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      @(negedge clk);
      chk("flush_stays_empty", out_valid, 0);
      do_op(4'b0100, 32'hFF00, 32'h0FF0, 5'd9);
      chk("post_flush_and", result, 32'h0F00);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         sel_op    = 4'($urandom_range(0, 15));
         op_a      = rnd_val();
         op_b      = ($urandom_range(0, 3) == 0) ? op_a : rnd_val();
         rd_in     = RW'($urandom);
         if (i == 1500) begin
            #3 rst_n = 1'b0;
            #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_in_ready", in_ready, 1);
            @(negedge clk); #1 rst_n = 1'b1;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("final_drained", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
